// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - 8N1 UART receiver that packs MEMORY_LENGTH bytes into an MSB-first word
`timescale 1ns/1ps
module uart_rx_buffer #(
    parameter int DELAY_FRAMES  = 234,
    parameter int MEMORY_LENGTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_rx,
    output logic [7:0]                 byte_out,
    output logic                       byte_valid,
    output logic [8*MEMORY_LENGTH-1:0] data_out,
    output logic                       word_valid,
    output logic                       frame_error
);
    localparam int CW = $clog2(DELAY_FRAMES);
    localparam int IW = (MEMORY_LENGTH > 1) ? $clog2(MEMORY_LENGTH) : 1;
    localparam int WW = 8 * MEMORY_LENGTH;
    localparam logic [CW-1:0] HALF_M1  = CW'(DELAY_FRAMES / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(DELAY_FRAMES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(MEMORY_LENGTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [1:0]    fill_q;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WW-1:0] buf_q, buf_d, word_next;
    logic [7:0]    byte_q, byte_d;
    logic [WW-1:0] data_q, data_d;
    logic          bv_q, bv_d, wv_q, wv_d, fe_q, fe_d;

    // rx_s only reflects the pin once fill_q[1] is set; armed_q records that the line
    // has been seen high since reset, so a line held low across reset lands in BREAK.
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q | (fill_q[1] & rx_s_q);
        cnt_d     = cnt_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        byte_d    = byte_q;
        data_d    = data_q;
        bv_d      = 1'b0;
        wv_d      = 1'b0;
        fe_d      = 1'b0;
        word_next = buf_q;
        for (int k = 0; k < MEMORY_LENGTH; k++) begin
            if (idx_q == IW'(k)) word_next[8*(MEMORY_LENGTH-1-k) +: 8] = shift_q;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fill_q[1] && !rx_s_q) state_d = armed_q ? S_START : S_BREAK;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        byte_d  = shift_q;
                        bv_d    = 1'b1;
                        buf_d   = word_next;
                        if (idx_q == LAST_IDX) begin
                            data_d = word_next;
                            wv_d   = 1'b1;
                            idx_d  = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            fill_q    <= '0;
            armed_q   <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
            buf_q     <= '0;
            byte_q    <= '0;
            data_q    <= '0;
            bv_q      <= 1'b0;
            wv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
            fill_q    <= {fill_q[0], 1'b1};
            armed_q   <= armed_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            byte_q    <= byte_d;
            data_q    <= data_d;
            bv_q      <= bv_d;
            wv_q      <= wv_d;
            fe_q      <= fe_d;
        end
    end

    assign byte_out    = byte_q;
    assign byte_valid  = bv_q;
    assign data_out    = data_q;
    assign word_valid  = wv_q;
    assign frame_error = fe_q;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - table-driven bench for uart_rx_buffer
`timescale 1ns/1ps
module tb_uart_rx_buffer;
    localparam int DF = 234;
    localparam int P_NONE = 0, P_RST = 1, P_GLITCH = 2, P_ABORT = 3;

    logic        clk, rst, uart_rx;
    logic [7:0]  byte_out;
    logic        byte_valid, word_valid, frame_error;
    logic [31:0] data_out;

    uart_rx_buffer #(.DELAY_FRAMES(DF), .MEMORY_LENGTH(4)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .byte_out(byte_out), .byte_valid(byte_valid),
        .data_out(data_out), .word_valid(word_valid), .frame_error(frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int          period;
        int          pre;
        int          idle;
        logic [7:0]  exp_byte;
        int          exp_bv;
        int          exp_fe;
        int          exp_wv;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[17];
    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0, last_bv_cyc = 0;
    int bv_cnt = 0, wv_cnt = 0, fe_cnt = 0, viol = 0;
    logic rst_edge = 1'b1;
    logic [31:0] prev_do = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_edge = rst;
    end

    // Pulse counters count high cycles, so a delta of 1 also proves a single-cycle pulse.
    always @(negedge clk) begin
        if (byte_valid) begin
            bv_cnt = bv_cnt + 1;
            last_bv_cyc = cyc;
        end
        if (word_valid) wv_cnt = wv_cnt + 1;
        if (frame_error) fe_cnt = fe_cnt + 1;
        if (byte_valid && frame_error) viol = viol + 1;
        if (word_valid && !byte_valid) viol = viol + 1;
        if (data_out !== prev_do && !word_valid && !rst_edge) viol = viol + 1;
        prev_do = data_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int period, input int rst_bit);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            if (i == 0) start_cyc = cyc;
            for (int c = 0; c < period; c++) begin
                rst = (rst_bit >= 0) && (i == rst_bit + 1) && (c == period / 2);
                @(negedge clk);
            end
        end
        rst = 1'b0;
    endtask

    task automatic hold_line(input logic level, input int n);
        uart_rx = level;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, w0, f0;
        vecs[0]  = '{8'hA5, 1'b1, DF,  P_NONE,   0,  8'hA5, 1, 0, 0, 32'h0};
        vecs[1]  = '{8'hDE, 1'b1, DF,  P_RST,    0,  8'hDE, 1, 0, 0, 32'h0};
        vecs[2]  = '{8'hAD, 1'b1, DF,  P_NONE,   0,  8'hAD, 1, 0, 0, 32'h0};
        vecs[3]  = '{8'hBE, 1'b1, DF,  P_NONE,   0,  8'hBE, 1, 0, 0, 32'h0};
        vecs[4]  = '{8'hEF, 1'b1, DF,  P_NONE,   0,  8'hEF, 1, 0, 1, 32'hDEADBEEF};
        vecs[5]  = '{8'h3C, 1'b1, DF,  P_GLITCH, 0,  8'h3C, 1, 0, 0, 32'hDEADBEEF};
        vecs[6]  = '{8'h11, 1'b1, DF,  P_RST,    0,  8'h11, 1, 0, 0, 32'h0};
        vecs[7]  = '{8'h22, 1'b1, DF,  P_NONE,   0,  8'h22, 1, 0, 0, 32'h0};
        vecs[8]  = '{8'h33, 1'b0, DF,  P_NONE,   20, 8'h22, 0, 1, 0, 32'h0};
        vecs[9]  = '{8'h44, 1'b1, DF,  P_NONE,   0,  8'h44, 1, 0, 0, 32'h0};
        vecs[10] = '{8'h55, 1'b1, DF,  P_NONE,   0,  8'h55, 1, 0, 1, 32'h11224455};
        vecs[11] = '{8'h7E, 1'b1, DF,  P_ABORT,  0,  8'h7E, 1, 0, 0, 32'h0};
        vecs[12] = '{8'h01, 1'b1, DF,  P_NONE,   0,  8'h01, 1, 0, 0, 32'h0};
        vecs[13] = '{8'h02, 1'b1, DF,  P_NONE,   0,  8'h02, 1, 0, 0, 32'h0};
        vecs[14] = '{8'h03, 1'b1, DF,  P_NONE,   0,  8'h03, 1, 0, 1, 32'h7E010203};
        vecs[15] = '{8'h55, 1'b1, 241, P_NONE,   0,  8'h55, 1, 0, 0, 32'h7E010203};
        vecs[16] = '{8'hAA, 1'b1, 241, P_NONE,   0,  8'hAA, 1, 0, 0, 32'h7E010203};

        uart_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset byte_out", byte_out, 0);
        check("reset byte_valid", byte_valid, 0);
        check("reset data_out", data_out, 0);
        check("reset word_valid", word_valid, 0);
        check("reset frame_error", frame_error, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            b0 = bv_cnt;
            w0 = wv_cnt;
            f0 = fe_cnt;
            case (vecs[i].pre)
                P_RST: begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    hold_line(1'b1, 5);
                end
                P_GLITCH: begin
                    hold_line(1'b0, 50);
                    hold_line(1'b1, 200);
                end
                P_ABORT: begin
                    send_frame(8'hF0, 1'b1, DF, 4);
                    hold_line(1'b1, 20);
                end
                default: ;
            endcase
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].period, -1);
            check($sformatf("v%0d byte_out", i), byte_out, vecs[i].exp_byte);
            check($sformatf("v%0d byte_valid pulses", i), bv_cnt - b0, vecs[i].exp_bv);
            check($sformatf("v%0d frame_error pulses", i), fe_cnt - f0, vecs[i].exp_fe);
            check($sformatf("v%0d word_valid pulses", i), wv_cnt - w0, vecs[i].exp_wv);
            check($sformatf("v%0d data_out", i), data_out, vecs[i].exp_word);
            if (i == 0) check("byte_valid latency", last_bv_cyc - start_cyc, 3 + DF / 2 + 9 * DF);
            if (vecs[i].idle > 0) hold_line(1'b1, vecs[i].idle);
        end

        hold_line(1'b1, 20);
        check("strobe and data_out invariants", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
